// File: rtl/spm_bank_arbiter_pkg.sv
// spm_pkg: shared widths and types for the scratchpad bank arbiter slice.
package spm_pkg;
    localparam int SPM_ADDR_W  = 9;
    localparam int SPM_DATA_W  = 32;
    localparam int SPM_MAX_REQ = 8;

    typedef struct packed {
        logic                  we;
        logic [SPM_ADDR_W-1:0] addr;
        logic [SPM_DATA_W-1:0] wdata;
    } spm_req_t;

    // Wide enough for the largest legal requester count.
    typedef logic [$clog2(SPM_MAX_REQ)-1:0] spm_req_idx_t;
endpackage

// File: rtl/spm_bank_arbiter_if.sv
// spm_bank_arbiter_if: requester-side and bank-side signals of one SPM bank.
// slave = the arbiter, master = requesters plus bank wrapper.
interface spm_bank_arbiter_if
    import spm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPM_ADDR_W,
    parameter int DATA_W  = SPM_DATA_W
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             req_gnt;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]              resp_rdata;
    logic                           bank_ren;
    logic                           bank_wen;
    logic [ADDR_W-1:0]              bank_addr;
    logic [DATA_W-1:0]              bank_wdata;
    logic [DATA_W-1:0]              bank_rdata;
    logic                           bank_rvalid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bank_rdata, bank_rvalid,
        output req_gnt, resp_valid, resp_rdata, bank_ren, bank_wen, bank_addr, bank_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bank_rdata, bank_rvalid,
        input  req_gnt, resp_valid, resp_rdata, bank_ren, bank_wen, bank_addr, bank_wdata
    );
endinterface

// File: rtl/spm_bank_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from rr_ptr upward
// and wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter
    import spm_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  spm_req_idx_t       rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output spm_req_idx_t       idx
);
    // First asserted request at or after rr_ptr wins.
    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = spm_req_idx_t'(j);
            end
        end
    end
endmodule

// File: rtl/spm_bank_arbiter.sv
// spm_bank_arbiter: sole master of one scratchpad bank. Round-robin grants one
// requester per cycle and routes the 1-cycle read response back by tag.
// Optional perf counters are built when SPM_ARB_PERF_EN is defined.
module spm_bank_arbiter
    import spm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPM_ADDR_W,
    parameter int DATA_W  = SPM_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    spm_bank_arbiter_if.slave         bus
`ifdef SPM_ARB_PERF_EN
    ,
    output logic [31:0]               perf_conflict_cnt,
    output logic [NUM_REQ-1:0][15:0]  perf_grant_cnt
`endif
);
    spm_req_idx_t       rr_ptr;
    spm_req_idx_t       idx;
    spm_req_idx_t       rd_tag;
    logic               rd_pending;
    logic [NUM_REQ-1:0] req_live;
    logic [NUM_REQ-1:0] gnt;
    logic               sel_we;
    logic               rsp_hit;

    // Requests are masked during reset so every output reads 0 while rst is high.
    assign req_live = bus.req_valid & {NUM_REQ{~rst}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (req_live),
        .rr_ptr (rr_ptr),
        .gnt    (gnt),
        .idx    (idx)
    );

    // One-hot mux of the winning request onto the bank port; zero when idle.
    always_comb begin
        sel_we         = 1'b0;
        bus.bank_addr  = '0;
        bus.bank_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we         = sel_we | (gnt[i] & bus.req_we[i]);
            bus.bank_addr  = bus.bank_addr  | ({ADDR_W{gnt[i]}} & bus.req_addr[i]);
            bus.bank_wdata = bus.bank_wdata | ({DATA_W{gnt[i]}} & bus.req_wdata[i]);
        end
        bus.req_gnt  = gnt;
        bus.bank_ren = (|gnt) & ~sel_we;
        bus.bank_wen = (|gnt) & sel_we;
    end

    // Pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (|gnt)
            rr_ptr <= (idx == spm_req_idx_t'(NUM_REQ - 1)) ? '0 : idx + spm_req_idx_t'(1);
    end

    // Remember who owns the read that the bank returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_tag     <= '0;
        end else begin
            rd_pending <= bus.bank_ren;
            if (bus.bank_ren) rd_tag <= idx;
        end
    end

    // Steer bank read data to the tagged requester; stray rvalid is dropped.
    always_comb begin
        rsp_hit        = bus.bank_rvalid & rd_pending;
        bus.resp_rdata = rsp_hit ? bus.bank_rdata : '0;
        bus.resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            bus.resp_valid[i] = rsp_hit & (rd_tag == spm_req_idx_t'(i));
    end

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst) bus.bank_rvalid |-> rd_pending);
    a_no_lost_rvalid:  assert property (@(posedge clk) disable iff (rst) rd_pending |-> bus.bank_rvalid);

`ifdef SPM_ARB_PERF_EN
    // Saturating contention counter and wrapping per-requester grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
            perf_grant_cnt    <= '0;
        end else begin
            if ($countones(bus.req_valid) > 1 && perf_conflict_cnt != 32'hFFFF_FFFF)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt[i]) perf_grant_cnt[i] <= perf_grant_cnt[i] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_spm_bank_arbiter.sv
// Directed bench for spm_bank_arbiter with a bank model and a response scoreboard.
module tb_spm_bank_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spm_bank_arbiter_if #(.NUM_REQ(N), .ADDR_W(9), .DATA_W(32)) bus ();

`ifdef SPM_ARB_PERF_EN
    logic [31:0]         pc;
    logic [N-1:0][15:0]  pg;
`endif

    spm_bank_arbiter #(.NUM_REQ(N), .ADDR_W(9), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SPM_ARB_PERF_EN
        ,
        .perf_conflict_cnt (pc),
        .perf_grant_cnt    (pg)
`endif
    );

    // Bank model: 1-cycle read latency, read-before-write in the same cycle.
    logic [31:0] mem [512];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bank_rvalid <= 1'b0;
            bus.bank_rdata  <= '0;
        end else begin
            bus.bank_rvalid <= bus.bank_ren;
            bus.bank_rdata  <= mem[bus.bank_addr];
            if (bus.bank_wen) mem[bus.bank_addr] = bus.bank_wdata;
        end
    end

    typedef struct {
        logic [N-1:0] v;
        logic [31:0]  d;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int total = 0;
    int bad   = 0;

    // Scoreboard monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.resp_valid !== '0) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got resp_valid=%b rdata=%h, want no response",
                         bus.resp_valid, bus.resp_rdata);
            end else begin
                e = q.pop_front();
                if ({bus.resp_valid, bus.resp_rdata} !== {e.v, e.d}) begin
                    bad++;
                    $display("FAIL resp: got resp_valid=%b rdata=%h, want resp_valid=%b rdata=%h",
                             bus.resp_valid, bus.resp_rdata, e.v, e.d);
                end
            end
        end
    end

    task automatic cmp_bank(input string name, input logic [N-1:0] g, input logic r,
                            input logic w, input logic [8:0] a, input logic [31:0] d);
        total++;
        if ({bus.req_gnt, bus.bank_ren, bus.bank_wen, bus.bank_addr, bus.bank_wdata} !== {g, r, w, a, d}) begin
            bad++;
            $display("FAIL %s: got gnt=%b ren=%b wen=%b addr=%h wdata=%h, want gnt=%b ren=%b wen=%b addr=%h wdata=%h",
                     name, bus.req_gnt, bus.bank_ren, bus.bank_wen, bus.bank_addr, bus.bank_wdata,
                     g, r, w, a, d);
        end
    endtask

    task automatic chk_bank(input string name, input logic [N-1:0] g, input logic r,
                            input logic w, input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        cmp_bank(name, g, r, w, a, d);
    endtask

    task automatic chk_resp_zero(input string name);
        total++;
        if ({bus.resp_valid, bus.resp_rdata} !== '0) begin
            bad++;
            $display("FAIL %s: got resp_valid=%b rdata=%h, want 0", name, bus.resp_valid, bus.resp_rdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read granted to requester k this cycle; its data is expected next cycle.
    task automatic rd(input string name, input int k, input logic [8:0] a, input logic [31:0] d);
        exp_t x;
        chk_bank(name, N'(1 << k), 1'b1, 1'b0, a, 32'h0);
        x.v = N'(1 << k);
        x.d = d;
        q.push_back(x);
        step();
    endtask

    task automatic idle(input string name);
        bus.req_valid = '0;
        bus.req_we    = '0;
        chk_bank(name, '0, 1'b0, 1'b0, 9'h0, 32'h0);
        step();
    endtask

    initial begin
        bus.req_valid = 4'hF;
        bus.req_we    = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < N; i++) bus.req_addr[i] = 9'h020 + 9'(i);
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        for (int i = 0; i < N; i++) mem[9'h020 + 9'(i)] = 32'h1000_0000 + i;
        mem[9'h010] = 32'hDEAD_BEEF;
        mem[9'h030] = 32'hA5A5_0000;
        mem[9'h033] = 32'hA5A5_0003;

        // Reset: outputs stay 0 even with every request raised.
        repeat (2) @(posedge clk);
        #1;
        chk_bank("reset_outputs", '0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk_resp_zero("reset_resp");
        bus.req_valid = '0;
        #1 rst = 1'b0;
        step();

        // Full contention: strict 0,1,2,3 rotation, twice.
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++)
            rd("contend", k % 4, 9'h020 + 9'(k % 4), 32'h1000_0000 + (k % 4));
        idle("contend_idle");

        // Single read by requester 2 (pointer is back at 0).
        bus.req_valid   = 4'b0100;
        bus.req_addr[2] = 9'h010;
        rd("single_rd", 2, 9'h010, 32'hDEAD_BEEF);
        idle("single_idle");

        // Pointer at 3: 3 first, then wrap to 0, then pointer 1 lets 3 win again.
        bus.req_valid   = 4'b1001;
        bus.req_addr[0] = 9'h030;
        bus.req_addr[3] = 9'h033;
        rd("wrap_3", 3, 9'h033, 32'hA5A5_0003);
        rd("wrap_0", 0, 9'h030, 32'hA5A5_0000);
        rd("wrap_3b", 3, 9'h033, 32'hA5A5_0003);
        idle("wrap_idle");

        // Write by 1, then read of the same word by 3 sees new data.
        bus.req_valid    = 4'b0010;
        bus.req_we       = 4'b0010;
        bus.req_addr[1]  = 9'h1FF;
        bus.req_wdata[1] = 32'h1234_5678;
        chk_bank("wr_1ff", 4'b0010, 1'b0, 1'b1, 9'h1FF, 32'h1234_5678);
        step();
        bus.req_valid    = 4'b1000;
        bus.req_we       = '0;
        bus.req_wdata[1] = '0;
        bus.req_addr[3]  = 9'h1FF;
        rd("rd_after_wr", 3, 9'h1FF, 32'h1234_5678);
        idle("wr_idle");

        // Reset lands between a read grant and its clock edge: no response.
        bus.req_valid   = 4'b0001;
        bus.req_addr[0] = 9'h020;
        chk_bank("rst_rd_gnt", 4'b0001, 1'b1, 1'b0, 9'h020, 32'h0);
        #2 rst = 1'b1;
        #1 cmp_bank("rst_async_out", '0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk_resp_zero("rst_async_resp");
        step();
        bus.req_valid   = 4'b0110;
        bus.req_addr[1] = 9'h021;
        bus.req_addr[2] = 9'h022;
        chk_bank("rst_hold_out", '0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk_resp_zero("rst_hold_resp");
        #1 rst = 1'b0;
        #1 cmp_bank("post_rst_gnt", 4'b0010, 1'b1, 1'b0, 9'h021, 32'h0);
        e.v = 4'b0010;
        e.d = 32'h1000_0001;
        q.push_back(e);
        step();
        idle("post_rst_idle");

`ifdef SPM_ARB_PERF_EN
        // Ten cycles of 0/1 contention (writes) from a fresh reset.
        rst = 1'b1;
        #1 rst = 1'b0;
        bus.req_valid    = 4'b0011;
        bus.req_we       = 4'b0011;
        bus.req_addr[0]  = 9'h100;
        bus.req_addr[1]  = 9'h101;
        repeat (10) @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        total++;
        if (pc !== 32'd10) begin
            bad++;
            $display("FAIL perf_conflict: got %0d, want 10", pc);
        end
        total++;
        if (pg[0] !== 16'd5 || pg[1] !== 16'd5) begin
            bad++;
            $display("FAIL perf_grant: got %0d/%0d, want 5/5", pg[0], pg[1]);
        end
        step();
`endif

        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_resp: got %0d outstanding, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spm_bank_arbiter.md
Name: spm_bank_arbiter

Overview:
- Sits directly upstream of one scratchpad SRAM bank wrapper and is the only master of that bank's control port.
- Arbitrates NUM_REQ requesters (PE load/store ports, DMA) onto the bank with round-robin, one grant per cycle.
- Tracks the requester of each in-flight read and steers the bank's 1-cycle-latency read response back to that requester.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ADDR_W, 9, word address width; matches the 512-word bank.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x ADDR_W  per-requester word address.
- req_wdata  in  NUM_REQ x DATA_W  per-requester write data.
- req_gnt  out  NUM_REQ  one-hot grant; the request is accepted in this cycle.
- resp_valid  out  NUM_REQ  one-hot read-response valid.
- resp_rdata  out  DATA_W  read data shared by all requesters; qualified by resp_valid.
- bank_ren  out  1  bank read enable.
- bank_wen  out  1  bank write enable.
- bank_addr  out  ADDR_W  bank address.
- bank_wdata  out  DATA_W  bank write data.
- bank_rdata  in  DATA_W  bank read data.
- bank_rvalid  in  1  bank read valid; arrives one cycle after bank_ren.

Behaviour:
- Reset values:
  - rr_ptr = 0.
  - rd_pending = 0; rd_tag = 0.
  - All outputs 0: req_gnt, resp_valid, bank_ren, bank_wen, bank_addr, bank_wdata, resp_rdata.
- Arbitration (combinational within a cycle):
  - Scan req_valid starting at index rr_ptr and wrap modulo NUM_REQ. The first asserted index i wins.
  - req_gnt[i] = 1.
  - bank_ren = ~req_we[i]; bank_wen = req_we[i]; bank_addr/bank_wdata = mux of index i.
  - If no request is asserted: req_gnt = 0, bank_ren = bank_wen = 0, bank_addr/bank_wdata = 0.
- Handshake:
  - A request is consumed when req_valid[i] & req_gnt[i].
  - Requesters hold valid/we/addr/wdata stable until granted.
  - Dropping req_valid before grant is legal; the request is simply withdrawn.
- Round-robin update:
  - On any grant to index i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - At NUM_REQ-1 the pointer wraps to 0.
- Read tracking:
  - rd_pending <= bank_ren.
  - rd_tag <= granted index when bank_ren; otherwise rd_tag holds.
- Response:
  - resp_valid[rd_tag] = bank_rvalid & rd_pending.
  - resp_rdata = bank_rdata when that is true, else 0.
  - Read latency, grant to resp_valid: exactly 1 cycle.
  - Back-to-back reads on consecutive cycles to different requesters return in the same order on consecutive cycles.
- Writes:
  - No response.
  - A read of the same address granted in the following cycle returns the new data (the bank is write-through).
- Boundary conditions:
  - bank_rvalid while rd_pending = 0: ignored, resp_valid stays 0; simulation assertion fires.
  - rd_pending = 1 and bank_rvalid = 0: response dropped; assertion fires.
  - All NUM_REQ requesting continuously: each is granted exactly once per NUM_REQ cycles.
  - Reset asserted mid-read: rd_pending clears immediately and no resp_valid is produced for that read. Requesters re-issue after reset.
- Starvation: bounded at NUM_REQ-1 cycles of wait for any continuously asserted request.

Optional Feature:
- Macro: SPM_ARB_PERF_EN.
- When defined, add:
  - Output perf_conflict_cnt, 32 bits: counts cycles with 2 or more req_valid asserted, saturating at 0xFFFF_FFFF.
  - Output perf_grant_cnt, NUM_REQ x 16 bits: per-requester grant counters that wrap.
  - Both reset to 0 asynchronously.
- When undefined, neither output exists and there is no added logic.

Decomposition:
- Package spm_pkg holds:
  - SPM_ADDR_W = 9 and SPM_DATA_W = 32.
  - typedef spm_req_t {we, addr, wdata}.
  - typedef spm_req_idx_t, sized by $clog2 of the maximum NUM_REQ.
- Sub-module rr_arbiter (NUM_REQ-parametric):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot gnt and the binary index.
  - Purely combinational. The pointer register stays in spm_bank_arbiter.

Test Plan:
- Single read:
  - Stimulus: preload addr 0x010 = 0xDEADBEEF; req 2 reads 0x010.
  - Required: req_gnt = 4'b0100 in cycle t; resp_valid = 4'b0100 and resp_rdata = 0xDEADBEEF in t+1; other resp_valid bits 0.
- Full contention:
  - Stimulus: all 4 requesters hold reads for 8 cycles from reset.
  - Required: grant order 0,1,2,3,0,1,2,3; each resp_valid arrives 1 cycle after its grant, tagged to the correct requester.
- Write then read:
  - Stimulus: req 1 writes 0x1FF = 0x12345678 in cycle t; req 3 reads 0x1FF in t+1.
  - Required: req 3 gets resp_rdata = 0x12345678 at t+2; the write produces no resp_valid.
- Pointer wrap:
  - Stimulus: rr_ptr = 3 (after a grant to 2); requesters 0 and 3 both request.
  - Required: 3 is granted first, then 0 in the next cycle; rr_ptr wraps to 0, then 1.
- Reset mid-read:
  - Stimulus: assert rst asynchronously between the grant of a read by req 0 and the next clock edge.
  - Required: resp_valid stays 0; all outputs 0 while rst is high; first post-reset grant goes to the lowest requesting index.
- With SPM_ARB_PERF_EN:
  - Stimulus: 10 cycles with requesters 0 and 1 both requesting.
  - Required: perf_conflict_cnt = 10; perf_grant_cnt[0] = 5, perf_grant_cnt[1] = 5.
